// File: rtl/ex_stage.sv
// Execute stage: EX pipeline register, operand select, ALU, data-SRAM request,
// EX forwarding port and a 32-cycle restoring divider for DIV/DIVU.
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [158:0] id_to_ex_bus,
    output logic [141:0] ex_to_mem_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         ex_wreg,
    output logic [4:0]   ex_waddr,
    output logic [31:0]  ex_wdata,
    output logic         stallreq_for_ex,
    output logic         stallreq_for_load
);

    localparam int         ID_TO_EX_WD = 159;
    localparam logic       STOP        = 1'b1;
    localparam logic       NO_STOP     = 1'b0;
    localparam logic [1:0] DIV_IDLE    = 2'd0;
    localparam logic [1:0] DIV_BUSY    = 2'd1;
    localparam logic [1:0] DIV_DONE    = 2'd2;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_neg);
        logic [31:0] m;
        if (is_neg) m = neg32(v);
        else        m = v;
        return m;
    endfunction

    logic [ID_TO_EX_WD-1:0] id_to_ex_r;
    logic [31:0] pc_s, inst_s, rdata1_s, rdata2_s;
    logic [11:0] alu_op_s;
    logic [2:0]  sel_src1_s;
    logic [3:0]  sel_src2_s;
    logic        ram_en_s, rf_we_s, sel_rf_res_s;
    logic [3:0]  ram_wen_s;
    logic [4:0]  rf_waddr_s;
    logic [13:0] unused_s;

    assign pc_s         = id_to_ex_r[158:127];
    assign inst_s       = id_to_ex_r[126:95];
    assign alu_op_s     = id_to_ex_r[94:83];
    assign sel_src1_s   = id_to_ex_r[82:80];
    assign sel_src2_s   = id_to_ex_r[79:76];
    assign ram_en_s     = id_to_ex_r[75];
    assign ram_wen_s    = id_to_ex_r[74:71];
    assign rf_we_s      = id_to_ex_r[70];
    assign rf_waddr_s   = id_to_ex_r[69:65];
    assign sel_rf_res_s = id_to_ex_r[64];
    assign rdata1_s     = id_to_ex_r[63:32];
    assign rdata2_s     = id_to_ex_r[31:0];
    assign unused_s     = {stall[5:4], stall[1:0], inst_s[25:16]};

    // EX pipeline register: a stalled EX with a running MEM becomes a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            id_to_ex_r <= {ID_TO_EX_WD{1'b0}};
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            id_to_ex_r <= {ID_TO_EX_WD{1'b0}};
        end else if (stall[2] == NO_STOP) begin
            id_to_ex_r <= id_to_ex_bus;
        end else begin
            id_to_ex_r <= id_to_ex_r;
        end
    end

    logic [31:0] src1_s, src2_s, slt_s, sltu_s, sra_s, alu_result_s;

    assign src1_s = ({32{sel_src1_s[0]}} & rdata1_s)
                  | ({32{sel_src1_s[1]}} & pc_s)
                  | ({32{sel_src1_s[2]}} & {27'd0, inst_s[10:6]});
    assign src2_s = ({32{sel_src2_s[0]}} & rdata2_s)
                  | ({32{sel_src2_s[1]}} & {{16{inst_s[15]}}, inst_s[15:0]})
                  | ({32{sel_src2_s[2]}} & 32'd8)
                  | ({32{sel_src2_s[3]}} & {16'd0, inst_s[15:0]});

    assign slt_s  = {31'd0, ($signed(src1_s) < $signed(src2_s))};
    assign sltu_s = {31'd0, (src1_s < src2_s)};
    assign sra_s  = $signed(src2_s) >>> src1_s[4:0];

    assign alu_result_s = ({32{alu_op_s[11]}} & (src1_s + src2_s))
                        | ({32{alu_op_s[10]}} & (src1_s - src2_s))
                        | ({32{alu_op_s[9]}}  & slt_s)
                        | ({32{alu_op_s[8]}}  & sltu_s)
                        | ({32{alu_op_s[7]}}  & (src1_s & src2_s))
                        | ({32{alu_op_s[6]}}  & ~(src1_s | src2_s))
                        | ({32{alu_op_s[5]}}  & (src1_s | src2_s))
                        | ({32{alu_op_s[4]}}  & (src1_s ^ src2_s))
                        | ({32{alu_op_s[3]}}  & (src2_s << src1_s[4:0]))
                        | ({32{alu_op_s[2]}}  & (src2_s >> src1_s[4:0]))
                        | ({32{alu_op_s[1]}}  & sra_s)
                        | ({32{alu_op_s[0]}}  & {src2_s[15:0], 16'd0});

    logic        is_div_s, div_signed_s;
    logic [1:0]  div_state_r;
    logic [4:0]  div_cnt_r;
    logic [31:0] div_rem_r, div_quo_r, div_dsr_r;
    logic        div_neg_q_r, div_neg_r_r;
    logic [32:0] div_partial_s, div_diff_s;
    logic        div_qbit_s;
    logic [31:0] div_rem_next_s;

    assign div_signed_s = (inst_s[5:0] == 6'h1A);
    assign is_div_s     = (inst_s[31:26] == 6'd0) &&
                          ((inst_s[5:0] == 6'h1A) || (inst_s[5:0] == 6'h1B));

    // quo_r starts as the dividend magnitude and shifts quotient bits in from the right
    assign div_partial_s  = {div_rem_r, div_quo_r[31]};
    assign div_diff_s     = div_partial_s - {1'b0, div_dsr_r};
    assign div_qbit_s     = ~div_diff_s[32];
    assign div_rem_next_s = div_qbit_s ? div_diff_s[31:0] : div_partial_s[31:0];

    // Divider FSM and datapath; DONE waits for the instruction to leave EX
    always_ff @(posedge clk) begin
        if (rst) begin
            div_state_r <= DIV_IDLE;
            div_cnt_r   <= 5'd0;
            div_rem_r   <= 32'd0;
            div_quo_r   <= 32'd0;
            div_dsr_r   <= 32'd0;
            div_neg_q_r <= 1'b0;
            div_neg_r_r <= 1'b0;
        end else begin
            case (div_state_r)
                DIV_IDLE: begin
                    if (is_div_s) begin
                        div_state_r <= DIV_BUSY;
                        div_cnt_r   <= 5'd0;
                        div_rem_r   <= 32'd0;
                        div_quo_r   <= mag32(rdata1_s, div_signed_s & rdata1_s[31]);
                        div_dsr_r   <= mag32(rdata2_s, div_signed_s & rdata2_s[31]);
                        div_neg_q_r <= div_signed_s & (rdata1_s[31] ^ rdata2_s[31]);
                        div_neg_r_r <= div_signed_s & rdata1_s[31];
                    end
                end
                DIV_BUSY: begin
                    div_rem_r <= div_rem_next_s;
                    div_quo_r <= {div_quo_r[30:0], div_qbit_s};
                    div_cnt_r <= div_cnt_r + 5'd1;
                    if (div_cnt_r == 5'd31) begin
                        div_state_r <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (stall[2] == NO_STOP) begin
                        div_state_r <= DIV_IDLE;
                    end
                end
                default: begin
                    div_state_r <= DIV_IDLE;
                end
            endcase
        end
    end

    logic        div_done_s;
    logic [31:0] hi_s, lo_s;

    assign div_done_s = (div_state_r == DIV_DONE);
    assign lo_s = div_done_s ? mag32(div_quo_r, div_neg_q_r) : 32'd0;
    assign hi_s = div_done_s ? mag32(div_rem_r, div_neg_r_r) : 32'd0;

    assign ex_to_mem_bus = {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s, rf_waddr_s,
                            alu_result_s, div_done_s, div_done_s, hi_s, lo_s};

    assign data_sram_en    = ram_en_s;
    assign data_sram_wen   = ram_wen_s;
    assign data_sram_addr  = alu_result_s;
    assign data_sram_wdata = rdata2_s;

    assign ex_wreg  = rf_we_s;
    assign ex_waddr = rf_waddr_s;
    assign ex_wdata = alu_result_s;

    assign stallreq_for_ex   = ((div_state_r == DIV_IDLE) && is_div_s) ||
                               (div_state_r == DIV_BUSY);
    assign stallreq_for_load = ram_en_s & ~(|ram_wen_s);

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ALU and
// divide traffic checked against an arithmetic reference model.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [141:0] ex_to_mem_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         ex_wreg;
    logic [4:0]   ex_waddr;
    logic [31:0]  ex_wdata;
    logic         stallreq_for_ex, stallreq_for_load;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .stallreq_for_ex(stallreq_for_ex), .stallreq_for_load(stallreq_for_load)
    );

    function automatic logic [158:0] mk_bus(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic [11:0] op, input logic [2:0] s1,
                                            input logic [3:0] s2, input logic en,
                                            input logic [3:0] wen, input logic we,
                                            input logic [4:0] wa, input logic selres,
                                            input logic [31:0] rd1, input logic [31:0] rd2);
        return {pc, inst, op, s1, s2, en, wen, we, wa, selres, rd1, rd2};
    endfunction

    // Reference ALU: op_idx is the alu_op bit position, 12 means no op selected
    function automatic logic [31:0] ref_alu(input int op_idx, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ext;
        int sh;
        sh  = int'(a % 32);
        ext = {{32{b[31]}}, b} >> sh;
        case (op_idx)
            11: return a + b;
            10: return a - b;
            9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8:  return (a < b) ? 32'd1 : 32'd0;
            7:  return a & b;
            6:  return ~(a | b);
            5:  return a | b;
            4:  return a ^ b;
            3:  return b << sh;
            2:  return b >> sh;
            1:  return ext[31:0];
            0:  return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r);
        logic na, nb;
        logic [31:0] ma, mb;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na != nb) q = 32'd0 - q;
        if (na) r = 32'd0 - r;
    endtask

    task automatic issue(input logic [158:0] b);
        id_to_ex_bus = b;
        stall = 6'b000000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 6'b000000;
        id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ex_to_mem_bus !== 142'd0 || stallreq_for_ex !== 1'b0 || stallreq_for_load !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus bus=%h sre=%b srl=%b required 0", ex_to_mem_bus, stallreq_for_ex, stallreq_for_load);
        end
        n_checks++;
        if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_wreg, ex_waddr, ex_wdata} !== 107'd0) begin
            n_fail++; $display("FAIL reset_ports en=%b wen=%h addr=%h wd=%h wreg=%b required 0", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_wreg);
        end
        rst = 1'b0;
    endtask

    task automatic test_addiu_ori_lui();
        issue(mk_bus(32'h0040_0000, {6'h09, 5'd1, 5'd9, 16'h0001}, 12'h800, 3'b001, 4'b0010,
                     1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'h7FFF_FFFF, 32'h0));
        n_checks++;
        if (ex_wdata !== 32'h8000_0000 || ex_wreg !== 1'b1 || ex_waddr !== 5'd9 || stallreq_for_ex !== 1'b0) begin
            n_fail++; $display("FAIL addiu wdata=%h wreg=%b waddr=%0d sre=%b required 80000000 1 9 0", ex_wdata, ex_wreg, ex_waddr, stallreq_for_ex);
        end
        issue(mk_bus(32'h0040_0004, {6'h0D, 5'd2, 5'd3, 16'hABCD}, 12'h020, 3'b001, 4'b1000,
                     1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h1234_0000, 32'h0));
        n_checks++;
        if (ex_to_mem_bus[97:66] !== 32'h1234_ABCD) begin
            n_fail++; $display("FAIL ori result=%h required 1234abcd", ex_to_mem_bus[97:66]);
        end
        issue(mk_bus(32'h0040_0008, {6'h0F, 5'd0, 5'd4, 16'hFFFF}, 12'h001, 3'b000, 4'b1000,
                     1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h5555_5555, 32'h0));
        n_checks++;
        if (ex_wdata !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL lui result=%h required ffff0000", ex_wdata);
        end
    endtask

    task automatic test_alu_random();
        for (int i = 0; i < 60; i++) begin
            int op_idx, s1_idx, s2_idx;
            logic [31:0] pc, inst, rd1, rd2, a, b, res;
            logic [3:0] wen;
            logic en, we, selres;
            logic [4:0] wa;
            logic [141:0] exp_bus;
            op_idx = $urandom_range(0, 12);
            s1_idx = $urandom_range(0, 3);
            s2_idx = $urandom_range(0, 4);
            pc = $urandom; rd1 = $urandom; rd2 = $urandom;
            inst = {6'h09, 26'($urandom)};
            en = 1'($urandom); wen = 4'($urandom_range(0, 1) * $urandom_range(0, 15));
            we = 1'($urandom); wa = 5'($urandom); selres = 1'($urandom);
            case (s1_idx)
                0: a = rd1;
                1: a = pc;
                2: a = {27'd0, inst[10:6]};
                default: a = 32'd0;
            endcase
            case (s2_idx)
                0: b = rd2;
                1: b = {{16{inst[15]}}, inst[15:0]};
                2: b = 32'd8;
                3: b = {16'd0, inst[15:0]};
                default: b = 32'd0;
            endcase
            res = ref_alu(op_idx, a, b);
            issue(mk_bus(pc, inst, (op_idx == 12) ? 12'd0 : 12'(1 << op_idx),
                         (s1_idx == 3) ? 3'd0 : 3'(1 << s1_idx),
                         (s2_idx == 4) ? 4'd0 : 4'(1 << s2_idx),
                         en, wen, we, wa, selres, rd1, rd2));
            exp_bus = {pc, en, wen, selres, we, wa, res, 2'b00, 64'd0};
            n_checks++;
            if (ex_to_mem_bus !== exp_bus || ex_wdata !== res || ex_wreg !== we || ex_waddr !== wa) begin
                n_fail++; $display("FAIL alu_rand op=%0d s1=%0d s2=%0d got=%h required=%h", op_idx, s1_idx, s2_idx, ex_to_mem_bus, exp_bus);
            end
            n_checks++;
            if (stallreq_for_load !== (en && wen == 4'h0) || data_sram_addr !== res || data_sram_wdata !== rd2
                || data_sram_en !== en || data_sram_wen !== wen || stallreq_for_ex !== 1'b0) begin
                n_fail++; $display("FAIL sram_rand en=%b wen=%h addr=%h srl=%b required %b %h %h %b", data_sram_en, data_sram_wen, data_sram_addr, stallreq_for_load, en, wen, res, en && wen == 4'h0);
            end
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] q, r;
        int cnt;
        ref_div(a, b, sgn, q, r);
        issue(mk_bus(32'h0040_1000, {6'h00, 5'd4, 5'd5, 10'd0, sgn ? 6'h1A : 6'h1B}, 12'd0, 3'd0,
                     4'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b));
        cnt = 0;
        while (stallreq_for_ex === 1'b1 && cnt < 100) begin
            stall = 6'b001111;
            cnt++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (cnt != 33) begin
            n_fail++; $display("FAIL div_stall_len cycles=%0d required 33", cnt);
        end
        n_checks++;
        if (ex_to_mem_bus[31:0] !== q || ex_to_mem_bus[63:32] !== r || ex_to_mem_bus[65:64] !== 2'b11) begin
            n_fail++; $display("FAIL div_result a=%h b=%h s=%b lo=%h hi=%h we=%b required %h %h 11", a, b, sgn, ex_to_mem_bus[31:0], ex_to_mem_bus[63:32], ex_to_mem_bus[65:64], q, r);
        end
    endtask

    task automatic test_div();
        do_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        n_checks++;
        if (ex_to_mem_bus[31:0] !== 32'hFFFF_FFFD || ex_to_mem_bus[63:32] !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL div_m7_by_2 lo=%h hi=%h required fffffffd ffffffff", ex_to_mem_bus[31:0], ex_to_mem_bus[63:32]);
        end
        do_div(32'h0000_0005, 32'h0000_0000, 1'b0);
        n_checks++;
        if (ex_to_mem_bus[31:0] !== 32'hFFFF_FFFF || ex_to_mem_bus[63:32] !== 32'h0000_0005) begin
            n_fail++; $display("FAIL divu_by_zero lo=%h hi=%h required ffffffff 00000005", ex_to_mem_bus[31:0], ex_to_mem_bus[63:32]);
        end
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_div(32'hFFFF_FFF0, 32'h0000_0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            do_div(a, b, 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        do_div(32'd100, 32'd7, 1'b0);
        do_div(32'hFFFF_FF9C, 32'd7, 1'b1);
        issue(mk_bus(32'h0, 32'h2400_0000, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd2,
                     1'b0, 32'd3, 32'd4));
        n_checks++;
        if (ex_wdata !== 32'd7 || stallreq_for_ex !== 1'b0 || ex_to_mem_bus[65:64] !== 2'b00) begin
            n_fail++; $display("FAIL after_div wdata=%h sre=%b we=%b required 7 0 00", ex_wdata, stallreq_for_ex, ex_to_mem_bus[65:64]);
        end
    endtask

    task automatic test_stall_bubble();
        logic [158:0] x;
        x = mk_bus(32'hBFC0_0010, {6'h09, 26'h0}, 12'h080, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1,
                   5'd6, 1'b1, 32'hF0F0_FFFF, 32'h0FF0_00FF);
        issue(x);
        id_to_ex_bus = ~x;
        stall = 6'b001111;
        @(posedge clk);
        #1;
        n_checks++;
        if (ex_to_mem_bus !== {32'hBFC0_0010, 1'b0, 4'h0, 1'b1, 1'b1, 5'd6, 32'h00F0_00FF, 66'd0}) begin
            n_fail++; $display("FAIL stall_hold bus=%h required pc bfc00010 result 00f000ff", ex_to_mem_bus);
        end
        stall = 6'b000111;
        @(posedge clk);
        #1;
        n_checks++;
        if (ex_to_mem_bus !== 142'd0 || ex_wreg !== 1'b0) begin
            n_fail++; $display("FAIL stall_bubble bus=%h wreg=%b required 0", ex_to_mem_bus, ex_wreg);
        end
        stall = 6'b000000;
    endtask

    task automatic test_reset_mid_busy();
        issue(mk_bus(32'h0, {6'h00, 20'd0, 6'h1B}, 12'd0, 3'd0, 4'd0, 1'b0, 4'h0, 1'b0, 5'd0,
                     1'b0, 32'd1000, 32'd3));
        stall = 6'b001111;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (stallreq_for_ex !== 1'b0 || ex_to_mem_bus !== 142'd0 || ex_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_busy sre=%b bus=%h required 0", stallreq_for_ex, ex_to_mem_bus);
        end
        rst = 1'b0;
        stall = 6'b000000;
        do_div(32'd1000, 32'd3, 1'b0);
    endtask

    task automatic test_store_load();
        issue(mk_bus(32'h0, {6'h2B, 5'd1, 5'd2, 16'h0008}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF,
                     1'b0, 5'd0, 1'b0, 32'h0000_0008, 32'hCAFE_F00D));
        n_checks++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== 4'hF || data_sram_addr !== 32'h10
            || data_sram_wdata !== 32'hCAFE_F00D || stallreq_for_load !== 1'b0) begin
            n_fail++; $display("FAIL store en=%b wen=%h addr=%h wd=%h srl=%b required 1 f 10 cafef00d 0", data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, stallreq_for_load);
        end
        issue(mk_bus(32'h0, {6'h23, 5'd1, 5'd2, 16'h0008}, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0,
                     1'b1, 5'd2, 1'b1, 32'h0000_0008, 32'h0));
        n_checks++;
        if (stallreq_for_load !== 1'b1 || data_sram_en !== 1'b1 || data_sram_wen !== 4'h0) begin
            n_fail++; $display("FAIL load srl=%b en=%b wen=%h required 1 1 0", stallreq_for_load, data_sram_en, data_sram_wen);
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 6'b000000;
        id_to_ex_bus = 159'd0;
        test_reset();
        test_addiu_ori_lui();
        test_alu_random();
        test_store_load();
        test_stall_bubble();
        test_div();
        test_back_to_back();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
